// File: rtl/life_step_scheduler.sv
// Generation scheduler for the 8x8 life grid: seed load, free-running RUN at a divided tick, single-step.
// Define LIFE_STILL_DET_EN to build the still/empty-board halt detector (HALT state, halted flag).
module life_step_scheduler #(
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      seed,
    input  logic             switch1,
    input  logic             switch2,
    input  logic [63:0]      next_grid,
    output logic [63:0]      grid,
    output logic             step,
    output logic [GEN_W-1:0] gen_count,
    output logic             halted,
    output logic [1:0]       state_o
);

    localparam int TC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_r;
    logic [TC_W-1:0]  tc_r;
    logic             sw2_q_r;
    logic [63:0]      grid_r;
    logic [GEN_W-1:0] gen_r;
    logic             step_r;
    logic             load_s;
    logic             edge2_s;

    // Generation counter sticks at all-ones instead of wrapping.
    function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
        return (v == {GEN_W{1'b1}}) ? v : v + GEN_W'(1);
    endfunction

    assign load_s  = switch1 & switch2;
    assign edge2_s = ~switch1 & switch2 & ~sw2_q_r;

`ifdef LIFE_STILL_DET_EN
    logic halted_r;
    logic still_s;
    assign still_s = (next_grid == grid_r) | (next_grid == 64'd0);
    assign halted  = halted_r;
`else
    assign halted  = 1'b0;
`endif

    assign grid      = grid_r;
    assign step      = step_r;
    assign gen_count = gen_r;
    assign state_o   = state_r;

    // Scheduler FSM: reset, then load, then per-state commit / transition decisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            tc_r     <= '0;
            sw2_q_r  <= 1'b0;
            grid_r   <= 64'd0;
            gen_r    <= '0;
            step_r   <= 1'b0;
`ifdef LIFE_STILL_DET_EN
            halted_r <= 1'b0;
`endif
        end else begin
            sw2_q_r <= switch2;
            step_r  <= 1'b0;
            if (load_s) begin
                grid_r   <= seed;
                gen_r    <= '0;
                tc_r     <= '0;
                state_r  <= ST_IDLE;
`ifdef LIFE_STILL_DET_EN
                halted_r <= 1'b0;
`endif
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (switch1) begin
                            state_r <= ST_RUN;
                            tc_r    <= '0;
                        end else if (edge2_s) begin
                            grid_r <= next_grid;
                            gen_r  <= sat_inc(gen_r);
                            step_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        // Falling run enable wins over a tick that lands on the same edge.
                        if (!switch1) begin
                            state_r <= ST_IDLE;
                            tc_r    <= '0;
                        end else if (tc_r == TC_LAST) begin
                            grid_r <= next_grid;
                            gen_r  <= sat_inc(gen_r);
                            step_r <= 1'b1;
                            tc_r   <= '0;
`ifdef LIFE_STILL_DET_EN
                            if (still_s) begin
                                state_r  <= ST_HALT;
                                halted_r <= 1'b1;
                            end else begin
                                state_r  <= ST_RUN;
                            end
`endif
                        end else begin
                            tc_r <= tc_r + TC_W'(1);
                        end
                    end
                    ST_HALT: begin
`ifdef LIFE_STILL_DET_EN
                        if (!switch1 && !switch2) begin
                            state_r  <= ST_IDLE;
                            halted_r <= 1'b0;
                        end else begin
                            state_r  <= ST_HALT;
                        end
`else
                        state_r <= ST_IDLE;
`endif
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        tc_r    <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_step_scheduler.sv
// Scoreboard bench for life_step_scheduler: main instance (TICK_DIV=4, GEN_W=8) plus a
// saturation instance (TICK_DIV=1, GEN_W=4).
module tb_life_step_scheduler;

    localparam logic [63:0] SEED = 64'h0412_6424_0034_3C28;

    logic        clk;
    logic        reset, sw1, sw2, stub_eq;
    logic [63:0] seed, next_grid, grid;
    logic        step, halted;
    logic [7:0]  gen_count;
    logic [1:0]  state_o;

    logic        reset2, sw1b, sw2b;
    logic [63:0] seed2, next_grid2, grid2;
    logic        step2, halted2;
    logic [3:0]  gen_count2;
    logic [1:0]  state_o2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int step_cnt = 0;
    int step2_cnt = 0;
    int enter_cyc = 0;
    int step_cyc[$];

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t exp_q[$];

    life_step_scheduler #(.TICK_DIV(4), .GEN_W(8)) dut (
        .clk(clk), .reset(reset), .seed(seed), .switch1(sw1), .switch2(sw2),
        .next_grid(next_grid), .grid(grid), .step(step), .gen_count(gen_count),
        .halted(halted), .state_o(state_o)
    );

    life_step_scheduler #(.TICK_DIV(1), .GEN_W(4)) dut_sat (
        .clk(clk), .reset(reset2), .seed(seed2), .switch1(sw1b), .switch2(sw2b),
        .next_grid(next_grid2), .grid(grid2), .step(step2), .gen_count(gen_count2),
        .halted(halted2), .state_o(state_o2)
    );

    assign next_grid  = stub_eq ? grid : {grid[62:0], grid[63]};
    assign next_grid2 = {grid2[62:0], grid2[63]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
        logic [63:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[62:0], r[63]};
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        exp_q.push_back('{tag, v});
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got %h expected a queued entry", obs);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (step) begin
            step_cnt++;
            step_cyc.push_back(cyc);
        end
        if (step2) step2_cnt++;
    endtask

    initial begin
        reset = 1'b1; sw1 = 1'b1; sw2 = 1'b1; seed = SEED; stub_eq = 1'b0;
        reset2 = 1'b1; sw1b = 1'b0; sw2b = 1'b0; seed2 = 64'd0;

        // reset beats load
        sb_push("rst_grid", 64'd0); sb_push("rst_gen", 64'd0); sb_push("rst_state", 64'd0);
        sb_push("rst_step", 64'd0); sb_push("rst_halted", 64'd0); sb_push("rst_gen2", 64'd0);
        repeat (2) tick();
        sb_pop(grid); sb_pop(64'(gen_count)); sb_pop(64'(state_o));
        sb_pop(64'(step)); sb_pop(64'(halted)); sb_pop(64'(gen_count2));

        // load
        reset = 1'b0;
        sb_push("load_grid", SEED); sb_push("load_gen", 64'd0); sb_push("load_state", 64'd0);
        tick();
        sb_pop(grid); sb_pop(64'(gen_count)); sb_pop(64'(state_o));
        sw1 = 1'b0; sw2 = 1'b0;
        tick();

        // free-running RUN, rotate-left stub
        sw1 = 1'b1;
        sb_push("run_steps", 64'd3); sb_push("run_first", 64'd4);
        sb_push("run_gap1", 64'd4); sb_push("run_gap2", 64'd4);
        sb_push("run_gen", 64'd3); sb_push("run_grid", rotl(SEED, 3)); sb_push("run_state", 64'd1);
        tick();
        enter_cyc = cyc;
        step_cnt = 0; step_cyc.delete();
        repeat (12) tick();
        sb_pop(64'(step_cnt));
        sb_pop(step_cyc.size() >= 1 ? 64'(step_cyc[0] - enter_cyc) : 64'd0);
        sb_pop(step_cyc.size() >= 2 ? 64'(step_cyc[1] - step_cyc[0]) : 64'd0);
        sb_pop(step_cyc.size() >= 3 ? 64'(step_cyc[2] - step_cyc[1]) : 64'd0);
        sb_pop(64'(gen_count)); sb_pop(grid); sb_pop(64'(state_o));
        sw1 = 1'b0;
        sb_push("exit_state", 64'd0); sb_push("exit_gen", 64'd3);
        tick();
        sb_pop(64'(state_o)); sb_pop(64'(gen_count));

        // single step held high
        sw2 = 1'b1; step_cnt = 0;
        sb_push("ss_latency", 64'd1); sb_push("ss_steps", 64'd1);
        sb_push("ss_gen", 64'd4); sb_push("ss_grid", rotl(SEED, 4));
        tick();
        sb_pop(64'(step));
        repeat (4) tick();
        sb_pop(64'(step_cnt)); sb_pop(64'(gen_count)); sb_pop(grid);
        sw2 = 1'b0;
        tick();
        sw2 = 1'b1; step_cnt = 0;
        sb_push("ss2_steps", 64'd1); sb_push("ss2_gen", 64'd5);
        repeat (2) tick();
        sb_pop(64'(step_cnt)); sb_pop(64'(gen_count));
        sw2 = 1'b0;
        tick();

        // still board
        stub_eq = 1'b1; sw1 = 1'b1;
        tick();
        repeat (4) tick();
`ifdef LIFE_STILL_DET_EN
        sb_push("halt_flag", 64'd1); sb_push("halt_state", 64'd2); sb_push("halt_gen", 64'd6);
        sb_pop(64'(halted)); sb_pop(64'(state_o)); sb_pop(64'(gen_count));
        sw1 = 1'b0; sw2 = 1'b1;
        sb_push("halt_hold_state", 64'd2); sb_push("halt_hold_gen", 64'd6);
        repeat (3) tick();
        sb_pop(64'(state_o)); sb_pop(64'(gen_count));
        sw2 = 1'b0;
        sb_push("halt_exit_state", 64'd0); sb_push("halt_exit_flag", 64'd0);
        tick();
        sb_pop(64'(state_o)); sb_pop(64'(halted));
`else
        sb_push("nohalt_flag", 64'd0); sb_push("nohalt_state", 64'd1); sb_push("nohalt_gen", 64'd6);
        sb_pop(64'(halted)); sb_pop(64'(state_o)); sb_pop(64'(gen_count));
        sb_push("nohalt_gen2", 64'd8); sb_push("nohalt_state2", 64'd1);
        repeat (8) tick();
        sb_pop(64'(gen_count)); sb_pop(64'(state_o));
        sw1 = 1'b0;
        tick();
`endif

        // reset mid-RUN with tc=2
        stub_eq = 1'b0; sw1 = 1'b1; sw2 = 1'b0;
        tick();
        repeat (2) tick();
        reset = 1'b1;
        sb_push("mrst_grid", 64'd0); sb_push("mrst_gen", 64'd0); sb_push("mrst_step", 64'd0);
        sb_push("mrst_state", 64'd0); sb_push("mrst_halted", 64'd0);
        tick();
        sb_pop(grid); sb_pop(64'(gen_count)); sb_pop(64'(step));
        sb_pop(64'(state_o)); sb_pop(64'(halted));
        reset = 1'b0; step_cnt = 0;
        sb_push("mrst_nostray", 64'd0); sb_push("mrst_run", 64'd1);
        sb_push("mrst_first", 64'd1); sb_push("mrst_gen1", 64'd1);
        repeat (4) tick();
        sb_pop(64'(step_cnt)); sb_pop(64'(state_o));
        tick();
        sb_pop(64'(step_cnt)); sb_pop(64'(gen_count));
        sw1 = 1'b0;
        tick();

        // saturation, TICK_DIV=1
        reset2 = 1'b0; sw1b = 1'b1; step2_cnt = 0;
        sb_push("sat_gen", 64'd15); sb_push("sat_steps", 64'd19); sb_push("sat_state", 64'd1);
        repeat (20) tick();
        sb_pop(64'(gen_count2)); sb_pop(64'(step2_cnt)); sb_pop(64'(state_o2));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
